// File: rtl/mac_table_pkg.sv
// Shared types for the MAC forwarding table: key width, entry key struct, FSM states.
package mac_table_pkg;
  localparam int MAC_W = 48;

  typedef struct packed {
    logic             vld;
    logic [MAC_W-1:0] mac;
  } entry_key_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/mac_table_match.sv
// Combinational associative search: one-hot match vector, hit flag, lowest free slot.
module mac_table_match
  import mac_table_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  entry_key_t [DEPTH-1:0] i_keys,
  input  logic [MAC_W-1:0]       i_key,
  output logic [DEPTH-1:0]       o_match,
  output logic                   o_hit,
  output logic [IDX_W-1:0]       o_free_idx,
  output logic                   o_full
);
  always_comb begin
    o_match    = '0;
    o_free_idx = '0;
    o_full     = 1'b1;
    // Walk downward so the last assignment leaves the lowest-index free slot.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      o_match[i] = i_keys[i].vld && (i_keys[i].mac == i_key);
      if (!i_keys[i].vld) begin
        o_full     = 1'b0;
        o_free_idx = IDX_W'(i);
      end
    end
  end

  assign o_hit = |o_match;
endmodule

// File: rtl/mac_table.sv
// Fully associative destination-MAC table with background flush and 2-cycle lookup.
// Optional statistics outputs are built when MAC_TABLE_STATS_EN is defined.
module mac_table
  import mac_table_pkg::*;
#(
  parameter int P_OUTPORT_WIDTH = 4,
  parameter int P_TABLE_DEPTH   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [47:0]                    i_update_dest_mac,
  input  logic [P_OUTPORT_WIDTH-1:0]     i_update_outport,
  input  logic                           i_update_flag,
  input  logic                           i_update_valid,
  input  logic                           i_flush,
  input  logic [47:0]                    i_lookup_mac,
  input  logic                           i_lookup_valid,
  output logic [P_OUTPORT_WIDTH-1:0]     o_lookup_outport,
  output logic                           o_lookup_flag,
  output logic                           o_lookup_hit,
  output logic                           o_lookup_valid,
  output logic                           o_update_drop,
  output logic                           o_busy,
  output logic [$clog2(P_TABLE_DEPTH):0] o_entry_count,
  output logic [15:0]                    o_drop_cnt
);
  localparam int D     = P_TABLE_DEPTH;
  localparam int OW    = P_OUTPORT_WIDTH;
  localparam int IDX_W = $clog2(D);
  localparam int CNT_W = IDX_W + 1;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      flush_idx_q, flush_idx_d;
  entry_key_t [D-1:0]    keys_q, keys_d;
  logic [D-1:0][OW-1:0]  port_q, port_d;
  logic [D-1:0]          flag_q, flag_d;
  logic                  drop_q, drop_d;
  logic                  new_write, clr_valid, flush_done;

  logic [1:0]            vld_pipe_q, vld_pipe_d;
  logic                  s1_hit_q, s1_hit_d, out_hit_q;
  logic [OW-1:0]         s1_port_q, s1_port_d, out_port_q;
  logic                  s1_flag_q, s1_flag_d, out_flag_q;

  logic [D-1:0]          upd_match, lk_match;
  logic                  upd_hit, upd_full;
  logic [IDX_W-1:0]      upd_free;
  logic                  lk_hit, unused_lk_full;
  logic [IDX_W-1:0]      unused_lk_free;

  mac_table_match #(.DEPTH(D)) u_upd_match (
    .i_keys(keys_q), .i_key(i_update_dest_mac),
    .o_match(upd_match), .o_hit(upd_hit), .o_free_idx(upd_free), .o_full(upd_full)
  );

  mac_table_match #(.DEPTH(D)) u_lk_match (
    .i_keys(keys_q), .i_key(i_lookup_mac),
    .o_match(lk_match), .o_hit(lk_hit), .o_free_idx(unused_lk_free), .o_full(unused_lk_full)
  );

  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    keys_d      = keys_q;
    port_d      = port_q;
    flag_d      = flag_q;
    drop_d      = 1'b0;
    new_write   = 1'b0;
    clr_valid   = 1'b0;
    flush_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_flush) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
          drop_d      = i_update_valid;
        end else if (i_update_valid) begin
          if (upd_hit) begin
            for (int i = 0; i < D; i++) begin
              if (upd_match[i]) begin
                port_d[i] = i_update_outport;
                flag_d[i] = i_update_flag;
              end
            end
          end else if (!upd_full) begin
            keys_d[upd_free].vld = 1'b1;
            keys_d[upd_free].mac = i_update_dest_mac;
            port_d[upd_free]     = i_update_outport;
            flag_d[upd_free]     = i_update_flag;
            new_write            = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        keys_d[flush_idx_q].vld = 1'b0;
        clr_valid               = keys_q[flush_idx_q].vld;
        drop_d                  = i_update_valid;
        if (i_flush) begin
          flush_idx_d = '0;
        end else if (flush_idx_q == IDX_W'(D - 1)) begin
          state_d    = ST_IDLE;
          flush_done = 1'b1;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 1 captures the result data itself, so later overwrites cannot leak into it.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], i_lookup_valid};
    s1_hit_d   = i_lookup_valid && lk_hit && (state_q == ST_IDLE);
    s1_port_d  = '0;
    s1_flag_d  = 1'b0;
    if (s1_hit_d) begin
      for (int i = 0; i < D; i++) begin
        if (lk_match[i]) begin
          s1_port_d = s1_port_d | port_q[i];
          s1_flag_d = s1_flag_d | flag_q[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
      keys_q      <= '0;
      port_q      <= '0;
      flag_q      <= '0;
      drop_q      <= 1'b0;
      vld_pipe_q  <= '0;
      s1_hit_q    <= 1'b0;
      s1_port_q   <= '0;
      s1_flag_q   <= 1'b0;
      out_hit_q   <= 1'b0;
      out_port_q  <= '0;
      out_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
      keys_q      <= keys_d;
      port_q      <= port_d;
      flag_q      <= flag_d;
      drop_q      <= drop_d;
      vld_pipe_q  <= vld_pipe_d;
      s1_hit_q    <= s1_hit_d;
      s1_port_q   <= s1_port_d;
      s1_flag_q   <= s1_flag_d;
      out_hit_q   <= s1_hit_q;
      out_port_q  <= s1_port_q;
      out_flag_q  <= s1_flag_q;
    end
  end

  assign o_lookup_valid   = vld_pipe_q[1];
  assign o_lookup_hit     = out_hit_q;
  assign o_lookup_outport = out_port_q;
  assign o_lookup_flag    = out_flag_q;
  assign o_update_drop    = drop_q;
  assign o_busy           = (state_q == ST_FLUSH);

`ifdef MAC_TABLE_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(new_write) - CNT_W'(clr_valid);
    drop_cnt_d = drop_cnt_q;
    if (flush_done) cnt_d = '0;
    if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_entry_count = cnt_q;
  assign o_drop_cnt    = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats  = ^{new_write, clr_valid, flush_done};
  assign o_entry_count = '0;
  assign o_drop_cnt    = '0;
`endif
endmodule

// File: tb/tb_mac_table.sv
// Self-checking bench for mac_table: directed vector table, corner sequences, random vs model.
module tb_mac_table;
  localparam int D  = 16;
  localparam int OW = 4;
  localparam int CW = $clog2(D) + 1;
`ifdef MAC_TABLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [47:0]   i_update_dest_mac;
  logic [OW-1:0] i_update_outport;
  logic          i_update_flag, i_update_valid, i_flush;
  logic [47:0]   i_lookup_mac;
  logic          i_lookup_valid;
  logic [OW-1:0] o_lookup_outport;
  logic          o_lookup_flag, o_lookup_hit, o_lookup_valid, o_update_drop, o_busy;
  logic [CW-1:0] o_entry_count;
  logic [15:0]   o_drop_cnt;

  mac_table #(.P_OUTPORT_WIDTH(OW), .P_TABLE_DEPTH(D)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_update_dest_mac(i_update_dest_mac), .i_update_outport(i_update_outport),
    .i_update_flag(i_update_flag), .i_update_valid(i_update_valid), .i_flush(i_flush),
    .i_lookup_mac(i_lookup_mac), .i_lookup_valid(i_lookup_valid),
    .o_lookup_outport(o_lookup_outport), .o_lookup_flag(o_lookup_flag),
    .o_lookup_hit(o_lookup_hit), .o_lookup_valid(o_lookup_valid),
    .o_update_drop(o_update_drop), .o_busy(o_busy),
    .o_entry_count(o_entry_count), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain arrays plus a countdown for the flush sweep.
  logic          m_v[D];
  logic [47:0]   m_mac[D];
  logic [OW-1:0] m_out[D];
  logic          m_flag[D];
  int            m_flush_left;
  int            m_dropcnt;
  logic          p_vld, p_hit, p_flag;   // result captured at lookup edge
  logic [OW-1:0] p_out;
  logic          e_vld, e_hit, e_flag, e_drop;
  logic [OW-1:0] e_out;

  typedef struct {
    bit          uv;
    logic [47:0] umac;
    logic [3:0]  uout;
    bit          uf;
    bit          lv;
    logic [47:0] lmac;
    bit          evld;
    bit          ehit;
    logic [3:0]  eout;
    bit          ef;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_v[i] = 1'b0; m_mac[i] = '0; m_out[i] = '0; m_flag[i] = 1'b0;
    end
    m_flush_left = 0; m_dropcnt = 0;
    p_vld = 0; p_hit = 0; p_flag = 0; p_out = '0;
    e_vld = 0; e_hit = 0; e_flag = 0; e_out = '0; e_drop = 0;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < D; i++) if (m_v[i]) n++;
    return n;
  endfunction

  task automatic model_step();
    int slot;
    e_vld = p_vld; e_hit = p_hit; e_out = p_out; e_flag = p_flag;
    p_vld = i_lookup_valid; p_hit = 0; p_out = '0; p_flag = 0;
    if (i_lookup_valid && m_flush_left == 0)
      for (int i = 0; i < D; i++)
        if (m_v[i] && m_mac[i] == i_lookup_mac) begin
          p_hit = 1; p_out = m_out[i]; p_flag = m_flag[i];
        end
    e_drop = 0;
    if (m_flush_left > 0) begin
      m_v[D - m_flush_left] = 1'b0;
      m_flush_left = i_flush ? D : m_flush_left - 1;
      e_drop = i_update_valid;
    end else if (i_flush) begin
      m_flush_left = D;
      e_drop = i_update_valid;
    end else if (i_update_valid) begin
      slot = -1;
      for (int i = 0; i < D; i++) if (m_v[i] && m_mac[i] == i_update_dest_mac) slot = i;
      if (slot < 0)
        for (int i = D - 1; i >= 0; i--) if (!m_v[i]) slot = i;
      if (slot < 0) e_drop = 1;
      else begin
        m_v[slot] = 1; m_mac[slot] = i_update_dest_mac;
        m_out[slot] = i_update_outport; m_flag[slot] = i_update_flag;
      end
    end
    if (e_drop && m_dropcnt < 65535) m_dropcnt++;
  endtask

  task automatic check_model();
    chk("lk_valid", o_lookup_valid, e_vld);
    chk("lk_hit", o_lookup_hit, e_hit);
    chk("lk_outport", o_lookup_outport, e_out);
    chk("lk_flag", o_lookup_flag, e_flag);
    chk("upd_drop", o_update_drop, e_drop);
    chk("busy", o_busy, m_flush_left > 0);
    chk("entry_count", o_entry_count, STATS ? m_count() : 0);
    chk("drop_cnt", o_drop_cnt, STATS ? m_dropcnt : 0);
  endtask

  // Called at a falling edge: drive, take one rising edge, then check at the next falling edge.
  task automatic cycle(input bit uv, input logic [47:0] umac, input logic [3:0] uout,
                       input bit uf, input bit lv, input logic [47:0] lmac, input bit fl);
    i_update_valid = uv; i_update_dest_mac = umac; i_update_outport = uout;
    i_update_flag = uf; i_lookup_valid = lv; i_lookup_mac = lmac; i_flush = fl;
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_model();
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, 0, '0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, o_lookup_valid, 0);
    chk({tag, "_hit"}, o_lookup_hit, 0);
    chk({tag, "_outport"}, o_lookup_outport, 0);
    chk({tag, "_flag"}, o_lookup_flag, 0);
    chk({tag, "_drop"}, o_update_drop, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_count"}, o_entry_count, 0);
    chk({tag, "_dropcnt"}, o_drop_cnt, 0);
  endtask

  initial begin
    tbl[0] = '{1, 48'h01, 4'd0, 0, 0, 48'h0,  0, 0, 4'd0, 0};
    tbl[1] = '{0, 48'h0,  4'd0, 0, 0, 48'h0,  0, 0, 4'd0, 0};
    tbl[2] = '{0, 48'h0,  4'd0, 0, 1, 48'h01, 0, 0, 4'd0, 0};
    tbl[3] = '{0, 48'h0,  4'd0, 0, 0, 48'h0,  1, 1, 4'd0, 0};
    tbl[4] = '{1, 48'h05, 4'd2, 1, 0, 48'h0,  0, 0, 4'd0, 0};
    tbl[5] = '{1, 48'h05, 4'd3, 0, 1, 48'h05, 0, 0, 4'd0, 0};
    tbl[6] = '{0, 48'h0,  4'd0, 0, 1, 48'h05, 1, 1, 4'd2, 1};
    tbl[7] = '{1, 48'h07, 4'd5, 1, 1, 48'h07, 1, 1, 4'd3, 0};
    tbl[8] = '{0, 48'h0,  4'd0, 0, 1, 48'h07, 1, 0, 4'd0, 0};
    tbl[9] = '{0, 48'h0,  4'd0, 0, 0, 48'h0,  1, 1, 4'd5, 1};

    i_rst_n = 1'b0;
    i_update_valid = 0; i_update_dest_mac = '0; i_update_outport = '0; i_update_flag = 0;
    i_flush = 0; i_lookup_valid = 0; i_lookup_mac = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed vectors: write/overwrite/same-edge visibility.
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].uv, tbl[i].umac, tbl[i].uout, tbl[i].uf, tbl[i].lv, tbl[i].lmac, 0);
      chk($sformatf("tbl%0d_valid", i), o_lookup_valid, tbl[i].evld);
      chk($sformatf("tbl%0d_hit", i), o_lookup_hit, tbl[i].ehit);
      chk($sformatf("tbl%0d_outport", i), o_lookup_outport, tbl[i].eout);
      chk($sformatf("tbl%0d_flag", i), o_lookup_flag, tbl[i].ef);
    end
    chk("count_after_overwrite", o_entry_count, STATS ? 3 : 0);

    // Fill to capacity, then one more key must be dropped.
    for (int i = 0; i < 13; i++) cycle(1, 48'h100 + 48'(i), 4'(i), 1, 0, '0, 0);
    cycle(1, 48'h999, 4'hF, 1, 0, '0, 0);
    chk("full_drop_pulse", o_update_drop, 1);
    chk("full_drop_cnt", o_drop_cnt, STATS ? 1 : 0);
    cycle(0, '0, '0, 0, 1, 48'h999, 0);
    chk("drop_pulse_width", o_update_drop, 0);
    idle();
    chk("dropped_key_valid", o_lookup_valid, 1);
    chk("dropped_key_hit", o_lookup_hit, 0);
    chk("dropped_key_outport", o_lookup_outport, 0);

    // Flush a full table: busy for exactly D cycles, lookups miss, updates dropped.
    cycle(0, '0, '0, 0, 0, '0, 1);
    chk("flush_busy_rise", o_busy, 1);
    for (int k = 0; k < D - 1; k++) begin
      cycle(k == 3, 48'h333, 4'd1, 0, 1, 48'h01, 0);
      chk($sformatf("flush_busy_%0d", k), o_busy, 1);
      if (k == 3) chk("flush_upd_drop", o_update_drop, 1);
      if (k >= 2) chk($sformatf("flush_lk_miss_%0d", k), o_lookup_hit, 0);
    end
    idle();
    chk("flush_busy_fall", o_busy, 0);
    chk("flush_count_zero", o_entry_count, 0);
    idle();
    chk("flush_last_lk_miss", o_lookup_hit, 0);

    // Flush restart mid-sweep.
    cycle(1, 48'h42, 4'd9, 1, 0, '0, 0);
    cycle(0, '0, '0, 0, 0, '0, 1);
    for (int k = 0; k < 5; k++) idle();
    cycle(0, '0, '0, 0, 0, '0, 1);
    for (int k = 0; k < D + 2; k++) idle();
    chk("restart_done", o_busy, 0);

    // Asynchronous reset with a lookup in flight and a flush running.
    cycle(1, 48'h42, 4'd9, 1, 0, '0, 0);
    cycle(0, '0, '0, 0, 1, 48'h42, 0);
    cycle(0, '0, '0, 0, 1, 48'h42, 1);
    chk("pre_rst_valid", o_lookup_valid, 1);
    chk("pre_rst_busy", o_busy, 1);
    i_update_valid = 0; i_flush = 0; i_lookup_valid = 0;
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midrst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle(0, '0, '0, 0, 1, 48'h42, 0);
    idle();
    chk("post_rst_miss", o_lookup_hit, 0);
    chk("post_rst_lk_valid", o_lookup_valid, 1);

    // Random traffic against the model; a small key pool forces hits, overwrites and drops.
    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 2) != 0, 48'hA0 + 48'($urandom_range(0, 21)), 4'($urandom),
            1'($urandom), $urandom_range(0, 1) == 1, 48'hA0 + 48'($urandom_range(0, 23)),
            $urandom_range(0, 59) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
